ifu: RTL and testbench

Instruction fetch unit for the single-issue RV32I core. It owns the fetch PC and issues word fetches over a req/ready + rvalid instruction-memory interface. It presents each fetched instruction and its address as registered IR/ip to the decode stage directly downstream. It inserts NOPs as bubbles and handles PC redirects from the execute stage (taken branch, JAL, JALR, trap).

---
 rtl/ifu.sv | 130 +++++++++++++
 tb/tb_ifu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// rtl/ifu.sv - RV32I instruction fetch unit: fetch PC, one outstanding imem fetch, skid buffer, redirects
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IR,
  output logic [31:0] ip,
  output logic        ir_valid,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] buf_q;
  logic [31:0] buf_pc_q;
  logic        kill_q;
  logic [31:0] ir_q;
  logic [31:0] ip_q;
  logic        ir_valid_q;
  logic        misalign_q;

  logic [31:0] pc_inc_d;
  logic [31:0] redir_pc_d;

  assign pc_inc_d   = pc_q + 32'd4;
  assign redir_pc_d = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      buf_q      <= NOP_INSN;
      buf_pc_q   <= RESET_PC;
      kill_q     <= 1'b0;
      ir_q       <= NOP_INSN;
      ip_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (redirect_valid) begin
        // A fetch already accepted by memory must still return; kill marks it stale.
        pc_q       <= redir_pc_d;
        ir_q       <= NOP_INSN;
        ir_valid_q <= 1'b0;
        misalign_q <= |redirect_pc[1:0];
        case (state_q)
          S_REQ: begin
            if (imem_ready) begin
              kill_q  <= 1'b1;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              kill_q  <= 1'b1;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end else begin
        // Bubble by default when decode is free; a delivery below overrides it.
        if (!stall) begin
          ir_q       <= NOP_INSN;
          ir_valid_q <= 1'b0;
        end
        case (state_q)
          S_REQ: begin
            if (imem_ready) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_inc_d;
              state_q  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= S_REQ;
              end else if (!stall) begin
                ir_q       <= imem_rdata;
                ip_q       <= req_pc_q;
                ir_valid_q <= 1'b1;
                state_q    <= S_REQ;
              end else begin
                buf_q    <= imem_rdata;
                buf_pc_q <= req_pc_q;
                state_q  <= S_FULL;
              end
            end
          end
          S_FULL: begin
            if (!stall) begin
              ir_q       <= buf_q;
              ip_q       <= buf_pc_q;
              ir_valid_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign imem_req       = (state_q == S_REQ) && rst_n;
  assign imem_addr      = pc_q;
  assign IR             = ir_q;
  assign ip             = ip_q;
  assign ir_valid       = ir_valid_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu: transaction-level fetch model plus directed literal checks
module tb_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IR;
  logic [31:0] ip;
  logic        ir_valid;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IR(IR), .ip(ip), .ir_valid(ir_valid), .fetch_misalign(fetch_misalign)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0100: return 32'h0640_0193;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Model: program-order fetch address, one in-flight fetch with a stale tag, queue of returned words
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] a;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_out_addr = 32'h0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  int          m_cnt = 0;

  logic [31:0] e_ir = NOP;
  logic [31:0] e_ip = 32'h0;
  bit          e_v = 1'b0;
  bit          e_mis = 1'b0;
  bit          e_req = 1'b0;
  bit          chk_en = 1'b0;

  int lat = 0;
  bit poison = 1'b0;
  bit junk = 1'b0;
  bit rs_knob = 1'b0;

  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    logic [31:0] n_ir, n_ip, dat;
    bit n_v, n_mis, resp, acc;
    ent_t ent;
    @(negedge clk);
    rst_n          = !rs_knob;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    resp           = m_out && (m_cnt == 0);
    dat            = poison ? 32'hDEAD_BEEF : mem_word(m_out_addr);
    imem_rvalid    = resp || (junk && !m_out);
    imem_rdata     = resp ? dat : 32'hBAD0_0BAD;
    n_ir = e_ir; n_ip = e_ip; n_v = e_v; n_mis = 1'b0;
    if (rs_knob) begin
      m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; q.delete();
      n_ir = NOP; n_ip = 32'h0; n_v = 1'b0;
    end else begin
      acc = !m_out && (q.size() == 0) && rdy;
      if (resp) begin
        if (!m_stale) begin
          ent.d = dat; ent.a = m_out_addr;
          q.push_back(ent);
        end
        m_out = 1'b0;
      end else if (m_out) begin
        m_cnt--;
      end
      if (acc) begin
        m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc; m_cnt = lat; m_pc = m_pc + 32'd4;
      end
      if (rd) begin
        q.delete();
        if (m_out) m_stale = 1'b1;
        m_pc  = {rpc[31:2], 2'b00};
        n_ir  = NOP; n_v = 1'b0;
        n_mis = |rpc[1:0];
      end else if (!st) begin
        if (q.size() > 0) begin
          n_ir = q[0].d; n_ip = q[0].a; n_v = 1'b1;
          void'(q.pop_front());
        end else begin
          n_ir = NOP; n_v = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    e_ir = n_ir; e_ip = n_ip; e_v = n_v; e_mis = n_mis;
    e_req = !rs_knob && !m_out && (q.size() == 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("IR", IR, e_ir);
      chk("ip", ip, e_ip);
      chk("ir_valid", {31'b0, ir_valid}, {31'b0, e_v});
      chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, e_mis});
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("imem_addr", imem_addr, m_pc);
    end
  end

  initial begin
    logic [31:0] rp;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    rs_knob = 1'b1;
    cyc(0, 0, 32'h0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 0);
    chk("rst_IR", IR, 32'h0000_0013);
    chk("rst_ip", ip, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rs_knob = 1'b0;

    cyc(0, 0, 32'h0, 0);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(0, 0, 32'h0, 1);
    chk("lat_wait_ir", IR, 32'h0000_0013);
    cyc(0, 0, 32'h0, 1);
    chk("first_ir", IR, 32'h0050_0093);
    chk("first_ip", ip, 32'h0);
    chk("first_v", {31'b0, ir_valid}, 32'h1);
    chk("next_addr", imem_addr, 32'h4);

    cyc(1, 0, 32'h0, 1);
    cyc(1, 0, 32'h0, 1);
    chk("full_noreq", {31'b0, imem_req}, 32'h0);
    chk("stall_hold_ir", IR, 32'h0050_0093);
    cyc(1, 0, 32'h0, 1);
    chk("stall_hold_ip", ip, 32'h0);
    cyc(0, 0, 32'h0, 0);
    chk("unstall_ir", IR, 32'h00A0_0113);
    chk("unstall_ip", ip, 32'h4);

    cyc(0, 1, 32'h100, 1);
    chk("redir_acc_ir", IR, 32'h0000_0013);
    chk("redir_acc_req", {31'b0, imem_req}, 32'h0);
    cyc(0, 0, 32'h0, 1);
    chk("stale8_dropped_v", {31'b0, ir_valid}, 32'h0);
    chk("redir_acc_addr", imem_addr, 32'h100);

    lat = 1; poison = 1'b1;
    cyc(0, 0, 32'h0, 1);
    cyc(0, 1, 32'h100, 1);
    cyc(0, 0, 32'h0, 1);
    chk("deadbeef_ir", IR, 32'h0000_0013);
    chk("deadbeef_v", {31'b0, ir_valid}, 32'h0);
    chk("deadbeef_addr", imem_addr, 32'h100);
    lat = 0; poison = 1'b0;
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 1);
    chk("tgt_ir", IR, 32'h0640_0193);
    chk("tgt_ip", ip, 32'h100);

    cyc(0, 1, 32'h202, 0);
    chk("mis_pulse", {31'b0, fetch_misalign}, 32'h1);
    chk("mis_addr", imem_addr, 32'h200);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'h0, 0);
      chk("nordy_req", {31'b0, imem_req}, 32'h1);
      chk("nordy_addr", imem_addr, 32'h200);
      chk("nordy_v", {31'b0, ir_valid}, 32'h0);
      chk("mis_clear", {31'b0, fetch_misalign}, 32'h0);
    end

    cyc(1, 0, 32'h0, 1);
    cyc(1, 0, 32'h0, 1);
    cyc(1, 1, 32'hFFFF_FFFC, 0);
    chk("full_redir_v", {31'b0, ir_valid}, 32'h0);
    chk("full_redir_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 1);
    chk("wrap_ip", ip, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    cyc(0, 0, 32'h0, 1);
    rs_knob = 1'b1;
    cyc(0, 0, 32'h0, 0);
    rs_knob = 1'b0; junk = 1'b1;
    cyc(0, 0, 32'h0, 0);
    junk = 1'b0;
    chk("late_rvalid_v", {31'b0, ir_valid}, 32'h0);
    chk("late_rvalid_ip", ip, 32'h0);

    for (int i = 0; i < 150; i++) begin
      lat  = i % 3;
      junk = (i % 7 == 3);
      rp   = 32'h400 + 32'(i * 8) + 32'(i % 2);
      cyc(i % 5 == 2, i % 17 == 9, rp, i % 4 != 1);
    end
    junk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
